// File: rtl/axi_stream_extract_header.sv
// rtl/axi_stream_extract_header.sv - strips the leading N bytes of each packet onto a header side-channel and realigns the payload
module axi_stream_extract_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int LEN_WD       = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_len,
    input  logic [LEN_WD-1:0]       len_extract,
    output logic                    ready_len,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    valid_header,
    output logic [DATA_WD-1:0]      header_out,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    input  logic                    ready_header,
    output logic                    short_pkt
);
    localparam int W = DATA_BYTE_WD;
    localparam logic [LEN_WD-1:0] W_LEN = LEN_WD'(W);

    typedef enum logic [1:0] {IDLE, HDR, BODY, FLUSH} state_t;
    state_t state, state_nxt;

    logic [LEN_WD-1:0]  n_len;
    logic [DATA_WD-1:0] res;
    logic [LEN_WD-1:0]  res_cnt;

    logic               out_free;
    logic               hdr_free;
    logic               in_fire;
    logic [LEN_WD-1:0]  k_in;
    logic [LEN_WD-1:0]  hdr_k;
    logic [DATA_WD-1:0] din_m;
    int                 sh_n;
    int                 sh_rest;
    int                 sh_hdr;

    function automatic logic [LEN_WD-1:0] popcnt(input logic [W-1:0] k);
        logic [LEN_WD-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) c = c + LEN_WD'(k[i]);
        return c;
    endfunction

    function automatic logic [W-1:0] msb_keep(input logic [LEN_WD-1:0] c);
        logic [W-1:0] ones;
        ones = '1;
        return ~(ones >> c);
    endfunction

    function automatic logic [W-1:0] lsb_keep(input logic [LEN_WD-1:0] c);
        logic [W-1:0] ones;
        ones = '1;
        return ~(ones << c);
    endfunction

    function automatic logic [DATA_WD-1:0] byte_mask(input logic [W-1:0] k);
        logic [DATA_WD-1:0] m;
        for (int i = 0; i < W; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    assign out_free = !valid_out || ready_out;
    assign hdr_free = !valid_header || ready_header;
    assign in_fire  = valid_in && ready_in;
    assign k_in     = popcnt(keep_in);
    assign hdr_k    = (k_in < n_len) ? k_in : n_len;
    // Disabled bytes are zeroed so partial beats never leak stale data downstream
    assign din_m    = data_in & byte_mask(keep_in);
    assign sh_n     = 8 * int'(n_len);
    assign sh_rest  = 8 * (W - int'(n_len));
    assign sh_hdr   = 8 * (W - int'(hdr_k));

    always_comb begin
        state_nxt = state;
        ready_len = 1'b0;
        ready_in  = 1'b0;
        case (state)
            IDLE: begin
                ready_len = 1'b1;
                if (valid_len) state_nxt = HDR;
            end
            HDR: begin
                // A single-beat packet may also need the payload register
                ready_in = hdr_free && out_free;
                if (valid_in && hdr_free && out_free) state_nxt = last_in ? IDLE : BODY;
            end
            BODY: begin
                ready_in = out_free;
                if (valid_in && out_free && last_in) state_nxt = (k_in > n_len) ? FLUSH : IDLE;
            end
            FLUSH: begin
                if (out_free) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            n_len        <= '0;
            res          <= '0;
            res_cnt      <= '0;
            valid_out    <= 1'b0;
            data_out     <= '0;
            keep_out     <= '0;
            last_out     <= 1'b0;
            valid_header <= 1'b0;
            header_out   <= '0;
            keep_header  <= '0;
            short_pkt    <= 1'b0;
        end else begin
            state     <= state_nxt;
            short_pkt <= 1'b0;
            if (valid_out && ready_out) valid_out <= 1'b0;
            if (valid_header && ready_header) valid_header <= 1'b0;
            if (valid_len && ready_len) n_len <= (len_extract > W_LEN) ? W_LEN : len_extract;

            if (in_fire && state == HDR) begin
                valid_header <= 1'b1;
                header_out   <= din_m >> sh_hdr;
                keep_header  <= lsb_keep(hdr_k);
                res          <= din_m << sh_n;
                res_cnt      <= (k_in > n_len) ? k_in - n_len : '0;
                if (last_in) begin
                    if (k_in < n_len) begin
                        short_pkt <= 1'b1;
                    end else if (k_in > n_len) begin
                        valid_out <= 1'b1;
                        data_out  <= din_m << sh_n;
                        keep_out  <= msb_keep(k_in - n_len);
                        last_out  <= 1'b1;
                    end
                end
            end

            if (in_fire && state == BODY) begin
                valid_out <= 1'b1;
                data_out  <= res | (din_m >> sh_rest);
                res       <= din_m << sh_n;
                res_cnt   <= (k_in > n_len) ? k_in - n_len : '0;
                if (last_in && k_in <= n_len) begin
                    keep_out <= msb_keep(W_LEN - n_len + k_in);
                    last_out <= 1'b1;
                end else begin
                    keep_out <= '1;
                    last_out <= 1'b0;
                end
            end

            if (state == FLUSH && out_free) begin
                valid_out <= 1'b1;
                data_out  <= res;
                keep_out  <= msb_keep(res_cnt);
                last_out  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axi_stream_extract_header.sv
// tb/tb_axi_stream_extract_header.sv - randomized bench with a byte-queue reference model for axi_stream_extract_header
module tb_axi_stream_extract_header;
    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_len = 1'b0;
    logic [2:0]  len_extract = '0;
    logic        ready_len;
    logic        valid_in = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  keep_in = '0;
    logic        last_in = 1'b0;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;
    logic        valid_header;
    logic [31:0] header_out;
    logic [3:0]  keep_header;
    logic        ready_header;
    logic        short_pkt;

    axi_stream_extract_header dut (
        .clk(clk), .rst(rst),
        .valid_len(valid_len), .len_extract(len_extract), .ready_len(ready_len),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
        .valid_header(valid_header), .header_out(header_out), .keep_header(keep_header), .ready_header(ready_header),
        .short_pkt(short_pkt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t       exp_pl_q[$];
    logic [31:0] exp_hdr_q[$];
    logic [3:0]  exp_hk_q[$];
    logic [31:0] pkt_d[$];
    logic [3:0]  pkt_k[$];
    int          short_exp = 0;
    int          short_seen = 0;
    int          total = 0;
    int          bad = 0;
    int          out_pct = 100;
    int          hdr_pct = 100;
    bit          chk_en = 1'b1;

    function automatic logic [31:0] bmask(input logic [3:0] k);
        logic [31:0] m;
        for (int i = 0; i < W; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference: flatten the packet into bytes, header = first min(L,N), payload = rest chunked into beats
    task automatic model_push(input int nraw);
        logic [7:0]  q[$];
        logic [31:0] hv;
        logic [31:0] d;
        beat_t       b;
        int          n, len, m, c, kc;
        n = (nraw > W) ? W : nraw;
        for (int i = 0; i < pkt_d.size(); i++) begin
            kc = $countones(pkt_k[i]);
            d  = pkt_d[i];
            for (int j = 0; j < kc; j++) q.push_back(d[8*(W-1-j) +: 8]);
        end
        len = q.size();
        m   = (len < n) ? len : n;
        hv  = '0;
        for (int j = 0; j < m; j++) hv = (hv << 8) | 32'(q[j]);
        exp_hdr_q.push_back(hv);
        exp_hk_q.push_back(4'((1 << m) - 1));
        if (len < n) short_exp++;
        for (int s = n; s < len; s += W) begin
            c   = (len - s < W) ? len - s : W;
            b.d = '0;
            for (int j = 0; j < c; j++) b.d[8*(W-1-j) +: 8] = q[s+j];
            b.k = 4'(((1 << c) - 1) << (W - c));
            b.l = (s + c >= len);
            exp_pl_q.push_back(b);
        end
    endtask

    // Drivers are entered and left at posedge+1
    task automatic send_len(input int nraw);
        int t;
        t = 0;
        valid_len   = 1'b1;
        len_extract = 3'(nraw);
        while (1) begin
            @(negedge clk);
            if (ready_len) break;
            t++;
            if (t > 3000) begin
                total++; bad++;
                $display("FAIL len_timeout ready_len=%b expected=1", ready_len);
                break;
            end
        end
        @(posedge clk); #1;
        valid_len = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int t;
        t = 0;
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        while (1) begin
            @(negedge clk);
            if (ready_in) break;
            t++;
            if (t > 3000) begin
                total++; bad++;
                $display("FAIL beat_timeout ready_in=%b expected=1", ready_in);
                break;
            end
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic run_pkt(input int nraw, input bit gaps);
        send_len(nraw);
        for (int i = 0; i < pkt_d.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_beat(pkt_d[i], pkt_k[i], i == pkt_d.size() - 1);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_pl_q.size() != 0 || exp_hdr_q.size() != 0 || valid_out || valid_header) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        total++;
        if (t >= 3000) begin
            bad++;
            $display("FAIL drain_timeout pl_left=%0d hdr_left=%0d expected=0", exp_pl_q.size(), exp_hdr_q.size());
        end
    endtask

    initial begin
        ready_out    = 1'b0;
        ready_header = 1'b0;
        forever begin
            @(posedge clk); #1;
            ready_out    = ($urandom_range(0, 99) < out_pct);
            ready_header = ($urandom_range(0, 99) < hdr_pct);
        end
    end

    initial begin : compare
        beat_t       e;
        logic [31:0] m;
        logic        sp_prev;
        sp_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && chk_en) begin
                if (valid_out && ready_out) begin
                    total++;
                    if (exp_pl_q.size() == 0) begin
                        bad++;
                        $display("FAIL payload_extra got data=%h keep=%b last=%b expected no beat", data_out, keep_out, last_out);
                    end else begin
                        e = exp_pl_q.pop_front();
                        m = bmask(e.k);
                        if ((data_out & m) !== e.d || keep_out !== e.k || last_out !== e.l) begin
                            bad++;
                            $display("FAIL payload got data=%h keep=%b last=%b expected data=%h keep=%b last=%b",
                                     data_out & m, keep_out, last_out, e.d, e.k, e.l);
                        end
                    end
                end
                if (valid_header && ready_header) begin
                    total++;
                    if (exp_hdr_q.size() == 0) begin
                        bad++;
                        $display("FAIL header_extra got hdr=%h keep=%b expected none", header_out, keep_header);
                    end else begin
                        m = exp_hdr_q.pop_front();
                        if (header_out !== m || keep_header !== exp_hk_q[0]) begin
                            bad++;
                            $display("FAIL header got hdr=%h keep=%b expected hdr=%h keep=%b",
                                     header_out, keep_header, m, exp_hk_q[0]);
                        end
                        void'(exp_hk_q.pop_front());
                    end
                end
                if (short_pkt) begin
                    total++;
                    if (short_seen >= short_exp || sp_prev) begin
                        bad++;
                        $display("FAIL short_pkt got pulse seen=%0d prev=%b expected count=%0d single-cycle", short_seen, sp_prev, short_exp);
                    end
                    short_seen++;
                end
                sp_prev = short_pkt;
            end else begin
                sp_prev = 1'b0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] stall;
        int          nb, nraw;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_len", 32'(ready_len), 32'd1);
        chk("rst_ready_in", 32'(ready_in), 32'd0);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_valid_header", 32'(valid_header), 32'd0);
        chk("rst_short_pkt", 32'(short_pkt), 32'd0);
        chk("rst_last_out", 32'(last_out), 32'd0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_header_out", header_out, 32'd0);
        chk("rst_keeps", {24'd0, keep_out, keep_header}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Two-beat packet, N=2
        pkt_d = {32'hAABBCCDD, 32'h11223344};
        pkt_k = {4'hF, 4'hF};
        model_push(2);
        chk("t1_model_hdr", exp_hdr_q[0], 32'h0000AABB);
        chk("t1_model_hkeep", 32'(exp_hk_q[0]), 32'h3);
        chk("t1_model_pl0", exp_pl_q[0].d, 32'hCCDD1122);
        chk("t1_model_pl1", exp_pl_q[1].d, 32'h33440000);
        chk("t1_model_pl1_kl", {27'd0, exp_pl_q[1].k, exp_pl_q[1].l}, {27'd0, 4'b1100, 1'b1});
        run_pkt(2, 1'b0);
        wait_drain();

        // Single beat exactly N bytes: header only
        pkt_d = {32'h12345678};
        pkt_k = {4'hF};
        model_push(4);
        chk("t2_model_hdr", exp_hdr_q[0], 32'h12345678);
        chk("t2_model_nopl", 32'(exp_pl_q.size()), 32'd0);
        run_pkt(4, 1'b0);
        wait_drain();

        // Short packet: 2 bytes against N=3
        pkt_d = {32'hCAFE9999};
        pkt_k = {4'b1100};
        model_push(3);
        chk("t3_model_hdr", exp_hdr_q[0], 32'h0000CAFE);
        chk("t3_model_short", 32'(short_exp), 32'd1);
        run_pkt(3, 1'b0);
        wait_drain();

        // N=0 passthrough with random backpressure
        out_pct = 50;
        pkt_d = {$urandom(), $urandom(), $urandom()};
        pkt_k = {4'hF, 4'hF, 4'hF};
        model_push(0);
        chk("t4_model_hkeep", 32'(exp_hk_q[0]), 32'h0);
        chk("t4_model_pl2", exp_pl_q[2].d, pkt_d[2]);
        run_pkt(0, 1'b1);
        wait_drain();
        out_pct = 100;

        // N=1, last beat 1 byte: one full last beat, then header backpressure stalls next packet
        hdr_pct = 0;
        pkt_d = {32'hAABBCCDD, 32'h11000000};
        pkt_k = {4'hF, 4'b1000};
        model_push(1);
        chk("t5_model_pl", exp_pl_q[0].d, 32'hBBCCDD11);
        chk("t5_model_pl_kl", {27'd0, exp_pl_q[0].k, exp_pl_q[0].l}, {27'd0, 4'hF, 1'b1});
        run_pkt(1, 1'b0);
        pkt_d = {32'h55667788};
        pkt_k = {4'hF};
        model_push(0);
        send_len(0);
        valid_in = 1'b1; data_in = 32'h55667788; keep_in = 4'hF; last_in = 1'b1;
        stall = 0;
        repeat (8) begin
            @(negedge clk);
            if (ready_in) stall++;
        end
        @(posedge clk); #1;
        chk("t5_hdr_stall", stall, 32'd0);
        hdr_pct = 100;
        send_beat(32'h55667788, 4'hF, 1'b1);
        wait_drain();

        // Reset in the middle of BODY
        out_pct = 0; hdr_pct = 0; chk_en = 1'b0;
        send_len(1);
        send_beat(32'h01020304, 4'hF, 1'b0);
        send_beat(32'h05060708, 4'hF, 1'b0);
        chk("t6_pre_valid_out", 32'(valid_out), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_valid_out", 32'(valid_out), 32'd0);
        chk("t6_valid_header", 32'(valid_header), 32'd0);
        chk("t6_last_out", 32'(last_out), 32'd0);
        chk("t6_data_out", data_out, 32'd0);
        chk("t6_ready_len", 32'(ready_len), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_pl_q.delete(); exp_hdr_q.delete(); exp_hk_q.delete();
        out_pct = 100; hdr_pct = 100; chk_en = 1'b1;
        @(posedge clk); #1;
        pkt_d = {32'hAABBCCDD, 32'h11223344};
        pkt_k = {4'hF, 4'hF};
        model_push(2);
        run_pkt(2, 1'b0);
        wait_drain();

        // Randomized packets under varying backpressure
        for (int p = 0; p < 160; p++) begin
            if (p % 20 == 0) begin
                out_pct = (p % 40 == 0) ? 100 : $urandom_range(30, 90);
                hdr_pct = (p % 60 == 0) ? 100 : $urandom_range(30, 90);
            end
            nraw = $urandom_range(0, 7);
            nb   = $urandom_range(1, 4);
            pkt_d = {};
            pkt_k = {};
            for (int b = 0; b < nb; b++) begin
                pkt_d.push_back($urandom());
                if (b < nb - 1) pkt_k.push_back(4'hF);
                else pkt_k.push_back(4'(((1 << ((nb == 1) ? $urandom_range(0, 4) : $urandom_range(1, 4))) - 1)
                                        << 0));
            end
            // Turn the drawn count into an MSB-contiguous keep
            pkt_k[nb-1] = 4'(((1 << $countones(pkt_k[nb-1])) - 1) << (W - $countones(pkt_k[nb-1])));
            model_push(nraw);
            run_pkt(nraw, 1'b1);
        end
        out_pct = 100; hdr_pct = 100;
        wait_drain();
        chk("short_count", 32'(short_seen), 32'(short_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
